// File: rtl/efuse_loader_pkg.sv
// Shared types and constants for the eFuse shadow loader.
package efuse_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    DONE,
    ERR
  } state_e;

  localparam logic [3:0]  WB_SEL_BYTE0 = 4'b0001;
  localparam int unsigned ADDR_STRIDE  = 4;

endpackage

// File: rtl/efuse_shadow_regs.sv
// NUM_BYTES x 8 shadow register file: one-hot write port, combinational read
// port that returns zero for indices beyond NUM_BYTES-1.
module efuse_shadow_regs
  import efuse_loader_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BYTES-1:0] we_i,
  input  logic [7:0]           wdata_i,
  input  logic [5:0]           rd_addr_i,
  output logic [7:0]           rd_data_o
);

  logic [NUM_BYTES-1:0][7:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_i[i]) mem_d[i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  // Decoded mux keeps out-of-range indices at zero for any NUM_BYTES.
  always_comb begin
    rd_data_o = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (rd_addr_i == 6'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule

// File: rtl/efuse_shadow_loader.sv
// Wishbone initiator that copies the eFuse image into a local shadow after reset
// or on start_i. Optional XOR checksum check: define EFUSE_LOADER_CHECKSUM_EN.
module efuse_shadow_loader
  import efuse_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NUM_BYTES = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        start_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic [5:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        crc_ok_o
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 auto_q, auto_d;
  logic                 start_load;
  logic                 wr_en;
  logic [NUM_BYTES-1:0] we;
  logic                 unused_dat_hi;

`ifdef EFUSE_LOADER_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic       crc_q, crc_d;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    auto_d     = auto_q;
    start_load = 1'b0;
    wr_en      = 1'b0;
`ifdef EFUSE_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
    crc_d      = crc_q;
`endif

    case (state_q)
      IDLE: begin
        // auto_q gives the one mandatory IDLE cycle after reset release.
        if (auto_q || start_i) start_load = 1'b1;
      end
      DONE, ERR: begin
        if (start_i) start_load = 1'b1;
        else         state_d    = IDLE;
      end
      REQ: begin
        if (wbm_ack_i) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef EFUSE_LOADER_CHECKSUM_EN
            crc_d   = (acc_q == wbm_dat_i[7:0]);
`endif
          end else begin
            state_d = GAP;
`ifdef EFUSE_LOADER_CHECKSUM_EN
            acc_d   = acc_q ^ wbm_dat_i[7:0];
`endif
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      GAP: begin
        idx_d   = idx_q + 6'd1;
        tmo_d   = 8'd0;
        state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (start_load) begin
      state_d = REQ;
      idx_d   = 6'd0;
      tmo_d   = 8'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
      auto_d  = 1'b0;
`ifdef EFUSE_LOADER_CHECKSUM_EN
      acc_d   = 8'h00;
      crc_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      tmo_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      auto_q  <= auto_d;
    end
  end

`ifdef EFUSE_LOADER_CHECKSUM_EN
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      acc_q <= 8'h00;
      crc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      crc_q <= crc_d;
    end
  end
  assign crc_ok_o = crc_q;
`else
  assign crc_ok_o = done_q;
`endif

  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      we[i] = wr_en && (idx_q == 6'(i));
    end
  end

  efuse_shadow_regs #(
    .NUM_BYTES (NUM_BYTES)
  ) u_regs (
    .clk       (wb_clk_i),
    .rst_n     (wb_rstn_i),
    .we_i      (we),
    .wdata_i   (wbm_dat_i[7:0]),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign unused_dat_hi = ^wbm_dat_i[31:8];

  assign wbm_cyc_o = (state_q == REQ);
  assign wbm_stb_o = (state_q == REQ);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = WB_SEL_BYTE0;
  assign wbm_adr_o = BASE_ADDR + 32'(ADDR_STRIDE) * {26'd0, idx_q};
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule
